alu_cmd_sequencer: RTL and testbench

Initiator side of the 16-bit ALU operand interface. It accepts bitwise-operation commands (func code, A, B) through a valid/ready port and buffers them in a small FIFO. It drives one command at a time onto the combinational ALU inputs, samples the ALU result after a fixed settle latency, and returns it on a valid/ready response port. It sits between the lab testbench or control logic and the ALU/bitwise datapath.

---
 rtl/alu_cmd_sequencer_pkg.sv | 27 ++
 rtl/alu_cmd_sequencer_cmd_fifo.sv | 54 +++++
 rtl/alu_cmd_sequencer.sv | 129 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Function codes mirror the bitwise ALU datapath encodings.
package alu_cmd_sequencer_pkg;

   localparam int DATA_W = 16;
   localparam int FUNC_W = 4;

   localparam logic [3:0] FUNC_AND  = 4'h0;
   localparam logic [3:0] FUNC_OR   = 4'h1;
   localparam logic [3:0] FUNC_XOR  = 4'h2;
   localparam logic [3:0] FUNC_NOT  = 4'h3;
   localparam logic [3:0] FUNC_NAND = 4'h4;
   localparam logic [3:0] FUNC_NOR  = 4'h5;
   localparam logic [3:0] FUNC_XNOR = 4'h6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_RESP  = 2'd2
   } seq_state_t;

   // FIFO payload is {func, a, b}
   function automatic int payload_width(input int dw, input int fw);
      return 2 * dw + fw;
   endfunction

endpackage

// File: rtl/alu_cmd_sequencer_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count.
// Head entry is presented combinationally on dout while not empty.
module alu_cmd_sequencer_cmd_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [PW:0]      count
);

   localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers are log2(DEPTH) wide, so wrap is the natural overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues queued bitwise commands to a combinational ALU one at a time,
// waits a fixed settle latency, and returns each result in order.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | nothing in flight; pop head of FIFO when available
// ST_DRIVE | alu_* held; wait_cnt counts settle cycles, then capture
// ST_RESP  | rsp_valid high, rsp_* held until rsp_ready
module alu_cmd_sequencer
   import alu_cmd_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_W,
   parameter int FUNC_WIDTH  = FUNC_W,
   parameter int DEPTH       = 4,
   parameter int ALU_LATENCY = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [FUNC_WIDTH-1:0] cmd_func,
   input  logic [DATA_WIDTH-1:0] cmd_a,
   input  logic [DATA_WIDTH-1:0] cmd_b,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic [FUNC_WIDTH-1:0] alu_func,
   input  logic [DATA_WIDTH-1:0] alu_c,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [FUNC_WIDTH-1:0] rsp_func,
   output logic                  busy
);

   localparam int          PW  = $clog2(DEPTH);
   localparam int          PLW = payload_width(DATA_WIDTH, FUNC_WIDTH);
   localparam logic [2:0]  LAT = 3'(ALU_LATENCY);

   seq_state_t            state;
   logic [2:0]            wait_cnt;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_pop;
   logic [PW:0]           fifo_count;
   logic [PLW-1:0]        fifo_din;
   logic [PLW-1:0]        fifo_dout;
   logic [FUNC_WIDTH-1:0] head_func;
   logic [DATA_WIDTH-1:0] head_a;
   logic [DATA_WIDTH-1:0] head_b;

   // cmd_ready comes from the registered count only: no pass-through when full.
   assign cmd_ready = !fifo_full;
   assign fifo_din  = {cmd_func, cmd_a, cmd_b};
   assign head_func = fifo_dout[PLW-1 -: FUNC_WIDTH];
   assign head_a    = fifo_dout[2*DATA_WIDTH-1 -: DATA_WIDTH];
   assign head_b    = fifo_dout[DATA_WIDTH-1:0];

   assign fifo_pop = !fifo_empty &&
                     ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));
   assign busy     = (fifo_count != '0) || (state != ST_IDLE);

   alu_cmd_sequencer_cmd_fifo #(
      .WIDTH (PLW),
      .DEPTH (DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (cmd_valid && cmd_ready),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         wait_cnt  <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_func  <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_func  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (fifo_pop) begin
                  alu_a    <= head_a;
                  alu_b    <= head_b;
                  alu_func <= head_func;
                  wait_cnt <= '0;
                  state    <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               if (wait_cnt == LAT) begin
                  rsp_data  <= alu_c;
                  rsp_func  <= alu_func;
                  rsp_valid <= 1'b1;
                  state     <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 3'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  // Back-to-back issue skips IDLE to keep one result per LAT+2 cycles.
                  if (fifo_pop) begin
                     alu_a    <= head_a;
                     alu_b    <= head_b;
                     alu_func <= head_func;
                     wait_cnt <= '0;
                     state    <= ST_DRIVE;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: reference queue of expected results computed from the
// bitwise function rules, checked against two instances (latency 0 and 3).
module tb_alu_cmd_sequencer;
   import alu_cmd_sequencer_pkg::*;

   typedef struct {
      logic [3:0]  f;
      logic [15:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;

   logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
   logic [3:0]  cmd_func, alu_func, rsp_func;
   logic [15:0] cmd_a, cmd_b, alu_a, alu_b, alu_c, rsp_data;

   logic        cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, busy3;
   logic [3:0]  cmd_func3, alu_func3, rsp_func3;
   logic [15:0] cmd_a3, cmd_b3, alu_a3, alu_b3, alu_c3, rsp_data3;

   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   exp_t q[$];
   exp_t q3[$];

   always #5 clk = ~clk;

   function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [15:0] a,
                                           input logic [15:0] b);
      case (f)
         FUNC_AND:  return a & b;
         FUNC_OR:   return a | b;
         FUNC_XOR:  return a ^ b;
         FUNC_NOT:  return ~a;
         FUNC_NAND: return ~(a & b);
         FUNC_NOR:  return ~(a | b);
         FUNC_XNOR: return ~(a ^ b);
         default:   return a + b;
      endcase
   endfunction

   function automatic exp_t mk(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      e.f = f;
      e.d = alu_ref(f, a, b);
      return e;
   endfunction

   assign alu_c = alu_ref(alu_func, alu_a, alu_b);

   // Latency-3 ALU model: output is X until operands have been stable for 3 edges.
   logic [2:0]  stable3 = 3'd0;
   logic [35:0] prev3   = '0;
   always @(posedge clk) begin
      #2;
      if ({alu_func3, alu_a3, alu_b3} !== prev3) begin
         prev3   = {alu_func3, alu_a3, alu_b3};
         stable3 = 3'd0;
      end else if (stable3 != 3'd7) begin
         stable3 = stable3 + 3'd1;
      end
   end
   assign alu_c3 = (stable3 >= 3'd3) ? alu_ref(alu_func3, alu_a3, alu_b3) : 16'hxxxx;

   alu_cmd_sequencer #(.ALU_LATENCY(0)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_c(alu_c),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_func(rsp_func), .busy(busy)
   );

   alu_cmd_sequencer #(.ALU_LATENCY(3)) dut3 (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_func(cmd_func3),
      .cmd_a(cmd_a3), .cmd_b(cmd_b3),
      .alu_a(alu_a3), .alu_b(alu_b3), .alu_func(alu_func3), .alu_c(alu_c3),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
      .rsp_func(rsp_func3), .busy(busy3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // One clock on the latency-0 instance with scoreboard bookkeeping.
   task automatic cycle();
      logic        push_f, rsp_f, stall;
      logic [15:0] d0;
      logic [3:0]  f0;
      exp_t        e;
      push_f = cmd_valid && cmd_ready;
      rsp_f  = rsp_valid && rsp_ready;
      stall  = rsp_valid && !rsp_ready;
      d0     = rsp_data;
      f0     = rsp_func;
      if (rsp_f) begin
         if (q.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid), 32'd0);
         end else begin
            e = q.pop_front();
            check("rsp_data", 32'(d0), 32'(e.d));
            check("rsp_func", 32'(f0), 32'(e.f));
         end
      end
      if (push_f) q.push_back(mk(cmd_func, cmd_a, cmd_b));
      tick();
      if (stall) begin
         check("stall_valid", 32'(rsp_valid), 32'd1);
         check("stall_data", 32'(rsp_data), 32'(d0));
         check("stall_func", 32'(rsp_func), 32'(f0));
      end
      check("busy", 32'(busy), 32'(q.size() != 0));
   endtask

   task automatic push_cmd(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
      logic ok;
      ok        = 1'b0;
      cmd_valid = 1'b1;
      cmd_func  = f;
      cmd_a     = a;
      cmd_b     = b;
      for (int k = 0; k < 50 && !ok; k++) begin
         ok = cmd_ready;
         cycle();
      end
      cmd_valid = 1'b0;
      check("push_accepted", 32'(ok), 32'd1);
   endtask

   task automatic rand_cmd();
      cmd_func = 4'($urandom_range(0, 15));
      cmd_a    = 16'($urandom);
      cmd_b    = 16'($urandom);
   endtask

   task automatic stream(input string tag, input int n, input logic toggle);
      int   sent;
      logic acc;
      sent      = 0;
      rand_cmd();
      cmd_valid = 1'b1;
      for (int k = 0; k < 400; k++) begin
         acc = cmd_valid && cmd_ready;
         cycle();
         if (toggle) rsp_ready = !rsp_ready;
         if (acc) begin
            sent++;
            if (sent < n) rand_cmd();
            else cmd_valid = 1'b0;
         end
         if (sent == n && q.size() == 0) break;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      check({tag, "_sent"}, 32'(sent), 32'(n));
      check({tag, "_drained"}, 32'(q.size()), 32'd0);
   endtask

   initial begin
      logic [15:0] a2;
      logic        acc;
      logic        prev;
      int          nr;
      int          t0;
      int          rise [3];
      exp_t        e;

      reset      = 1'b1;
      cmd_valid  = 1'b0; cmd_func  = '0; cmd_a  = '0; cmd_b  = '0; rsp_ready  = 1'b0;
      cmd_valid3 = 1'b0; cmd_func3 = '0; cmd_a3 = '0; cmd_b3 = '0; rsp_ready3 = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_alu_b", 32'(alu_b), 32'd0);
      check("rst_alu_func", 32'(alu_func), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      check("rst_rsp_func", 32'(rsp_func), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp_valid3", 32'(rsp_valid3), 32'd0);

      // Single AND, latency 0
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_func = FUNC_AND; cmd_a = 16'hF0F0; cmd_b = 16'h3C3C;
      cycle();
      cmd_valid = 1'b0;
      check("and_t0_valid", 32'(rsp_valid), 32'd0);
      cycle();
      check("and_t1_valid", 32'(rsp_valid), 32'd0);
      check("and_alu_a", 32'(alu_a), 32'h0000F0F0);
      check("and_alu_func", 32'(alu_func), 32'(FUNC_AND));
      cycle();
      check("and_t2_valid", 32'(rsp_valid), 32'd1);
      check("and_data", 32'(rsp_data), 32'h00003030);
      check("and_func", 32'(rsp_func), 32'(FUNC_AND));
      cycle();
      check("and_busy_done", 32'(busy), 32'd0);
      check("and_alu_hold", 32'(alu_b), 32'h00003C3C);

      // Fill FIFO under backpressure
      rsp_ready = 1'b0;
      push_cmd(FUNC_XOR,  16'hAAAA, 16'h5555);
      push_cmd(FUNC_NOR,  16'hAAAA, 16'h5555);
      push_cmd(FUNC_NOT,  16'hAAAA, 16'h5555);
      push_cmd(FUNC_OR,   16'hAAAA, 16'h5555);
      push_cmd(FUNC_NAND, 16'hAAAA, 16'h5555);
      cmd_valid = 1'b1; cmd_func = FUNC_XNOR; cmd_a = 16'hAAAA; cmd_b = 16'h5555;
      cycle();
      cycle();
      check("fill_cmd_ready", 32'(cmd_ready), 32'd0);
      check("fill_rsp_valid", 32'(rsp_valid), 32'd1);
      check("fill_first_data", 32'(rsp_data), 32'h0000FFFF);
      rsp_ready = 1'b1;
      for (int k = 0; k < 100; k++) begin
         acc = cmd_valid && cmd_ready;
         cycle();
         if (acc) cmd_valid = 1'b0;
         if (!cmd_valid && q.size() == 0) break;
      end
      check("fill_sixth_accepted", 32'(cmd_valid), 32'd0);
      check("fill_drained", 32'(q.size()), 32'd0);

      // Random stream with rsp_ready toggling every cycle
      rsp_ready = 1'b0;
      stream("bp", 10, 1'b1);

      // Wrap-around with continuous push and consume
      rsp_ready = 1'b1;
      stream("wrap", 12, 1'b0);

      // Latency 3 instance: captured value and 5-cycle spacing
      rsp_ready3 = 1'b1;
      t0 = 0;
      for (int i = 0; i < 3; i++) begin
         cmd_valid3 = 1'b1;
         cmd_func3  = 4'($urandom_range(0, 6));
         cmd_a3     = 16'($urandom);
         cmd_b3     = 16'($urandom);
         check("lat3_cmd_ready", 32'(cmd_ready3), 32'd1);
         q3.push_back(mk(cmd_func3, cmd_a3, cmd_b3));
         tick();
         if (i == 0) t0 = cyc;
      end
      cmd_valid3 = 1'b0;
      nr   = 0;
      prev = rsp_valid3;
      rise = '{0, 0, 0};
      for (int k = 0; k < 60 && nr < 3; k++) begin
         tick();
         if (rsp_valid3 && !prev) begin
            rise[nr] = cyc;
            e = q3.pop_front();
            check("lat3_data", 32'(rsp_data3), 32'(e.d));
            check("lat3_func", 32'(rsp_func3), 32'(e.f));
            nr++;
         end
         prev = rsp_valid3;
      end
      check("lat3_count", 32'(nr), 32'd3);
      check("lat3_first_latency", 32'(rise[0] - t0), 32'd5);
      check("lat3_gap1", 32'(rise[1] - rise[0]), 32'd5);
      check("lat3_gap2", 32'(rise[2] - rise[1]), 32'd5);
      tick();
      check("lat3_busy_done", 32'(busy3), 32'd0);

      // Reset while the second of three commands is in DRIVE
      rsp_ready = 1'b1;
      push_cmd(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      a2 = 16'($urandom);
      push_cmd(FUNC_XOR, a2, 16'($urandom));
      push_cmd(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      for (int k = 0; k < 20 && q.size() != 2; k++) cycle();
      check("mid_second_issued", 32'(alu_a), 32'(a2));
      check("mid_in_drive", 32'(rsp_valid), 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      q.delete();
      check("mid_rst_alu_a", 32'(alu_a), 32'd0);
      check("mid_rst_alu_func", 32'(alu_func), 32'd0);
      check("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      for (int k = 0; k < 8; k++) begin
         cycle();
         check("mid_no_rsp", 32'(rsp_valid), 32'd0);
      end
      push_cmd(FUNC_NAND, 16'h1234, 16'hFF00);
      for (int k = 0; k < 20 && q.size() != 0; k++) cycle();
      check("mid_after_reset_done", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
